// File: rtl/matmul_dot_if.sv
// Handshake and memory-port bundle between the 8x8 matmul engine and its operand/result RAMs.
interface matmul_dot_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
);
  logic                     start;
  logic [5:0]               a_addr1;
  logic [5:0]               a_addr2;
  logic [5:0]               b_addr1;
  logic [5:0]               b_addr2;
  logic signed [DATA_W-1:0] a_data1;
  logic signed [DATA_W-1:0] a_data2;
  logic signed [DATA_W-1:0] b_data1;
  logic signed [DATA_W-1:0] b_data2;
  logic                     a_we;
  logic [5:0]               c_addr;
  logic signed [ACC_W-1:0]  c_data;
  logic                     c_we;
  logic                     busy;
  logic                     done;
  logic [15:0]              cycle_count;

  modport master (
    output start, a_data1, a_data2, b_data1, b_data2,
    input  a_addr1, a_addr2, b_addr1, b_addr2, a_we,
    input  c_addr, c_data, c_we, busy, done, cycle_count
  );

  modport slave (
    input  start, a_data1, a_data2, b_data1, b_data2,
    output a_addr1, a_addr2, b_addr1, b_addr2, a_we,
    output c_addr, c_data, c_we, busy, done, cycle_count
  );
endinterface

// File: rtl/matmul_dot_engine.sv
// 8x8 signed matrix multiply sequencer: two k-terms per cycle, 4 issues per C element.
// Optional MATMUL_RELU_EN clamps negative results to zero on the C write path.
module matmul_dot_engine #(
  parameter int DATA_W = 8,
  parameter int DIM    = 8,
  parameter int ACC_W  = 19
) (
  input  logic         clk,
  input  logic         reset,
  matmul_dot_if.slave  bus
);

  localparam int IDX_W = $clog2(DIM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic signed [ACC_W-1:0] dot2(
    input logic signed [DATA_W-1:0] a1, input logic signed [DATA_W-1:0] a2,
    input logic signed [DATA_W-1:0] b1, input logic signed [DATA_W-1:0] b2);
    logic signed [2*DATA_W-1:0] p1;
    logic signed [2*DATA_W-1:0] p2;
    p1 = a1 * b1;
    p2 = a2 * b2;
    return {{(ACC_W-2*DATA_W){p1[2*DATA_W-1]}}, p1} +
           {{(ACC_W-2*DATA_W){p2[2*DATA_W-1]}}, p2};
  endfunction

  function automatic logic signed [ACC_W-1:0] write_value(input logic signed [ACC_W-1:0] v);
`ifdef MATMUL_RELU_EN
    return v[ACC_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Issue n = {i,j,kp}: A walks row i over k = 2kp,2kp+1; B walks column j over the same k.
  function automatic logic [23:0] issue_addrs(input logic [7:0] n);
    logic [2:0] i;
    logic [2:0] j;
    logic [1:0] kp;
    i  = n[7:5];
    j  = n[4:2];
    kp = n[1:0];
    return {i, kp, 1'b0, i, kp, 1'b1, kp, 1'b0, j, kp, 1'b1, j};
  endfunction

  state_t                    state_q, state_d;
  logic [7:0]                n_q, n_d;
  logic [23:0]               addr_q, addr_d;
  logic                      vld_p1_q, vld_p1_d;
  logic [1:0]                kp_p1_q, kp_p1_d;
  logic [2*IDX_W-1:0]        ij_p1_q, ij_p1_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   psum;
  logic                      c_we_q, c_we_d;
  logic [5:0]                c_addr_q, c_addr_d;
  logic signed [ACC_W-1:0]   c_data_q, c_data_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [15:0]               busy_cnt_q, busy_cnt_d;
  logic [15:0]               cycle_count_q, cycle_count_d;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    addr_d   = '0;
    vld_p1_d = 1'b0;
    kp_p1_d  = n_q[1:0];
    ij_p1_d  = n_q[7:2];
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          n_d     = '0;
          addr_d  = issue_addrs(8'd0);
        end
      end
      S_RUN: begin
        vld_p1_d = 1'b1;
        n_d      = n_q + 8'd1;
        if (n_q == 8'd255) state_d = S_DRAIN;
        else               addr_d  = issue_addrs(n_q + 8'd1);
      end
      S_DRAIN: begin
        if (c_we_q && c_addr_q == 6'd63) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    busy_cnt_d    = (state_q == S_IDLE) ? 16'd0 : busy_cnt_q + 16'd1;
    cycle_count_d = (state_q == S_DONE) ? busy_cnt_q + 16'd1 : cycle_count_q;
  end

  // Stage p1: operand data returns from the RAMs alongside the delayed issue tags.
  always_comb begin
    psum     = dot2(bus.a_data1, bus.a_data2, bus.b_data1, bus.b_data2);
    acc_d    = acc_q;
    c_we_d   = 1'b0;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    if (vld_p1_q) begin
      acc_d = (kp_p1_q == 2'd0) ? psum : acc_q + psum;
      if (kp_p1_q == 2'd3) begin
        c_we_d   = 1'b1;
        c_addr_d = ij_p1_q;
        c_data_d = write_value(acc_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      addr_q        <= '0;
      vld_p1_q      <= 1'b0;
      kp_p1_q       <= '0;
      ij_p1_q       <= '0;
      acc_q         <= '0;
      c_we_q        <= 1'b0;
      c_addr_q      <= '0;
      c_data_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_cnt_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      addr_q        <= addr_d;
      vld_p1_q      <= vld_p1_d;
      kp_p1_q       <= kp_p1_d;
      ij_p1_q       <= ij_p1_d;
      acc_q         <= acc_d;
      c_we_q        <= c_we_d;
      c_addr_q      <= c_addr_d;
      c_data_q      <= c_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      busy_cnt_q    <= busy_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.a_addr1     = addr_q[23:18];
  assign bus.a_addr2     = addr_q[17:12];
  assign bus.b_addr1     = addr_q[11:6];
  assign bus.b_addr2     = addr_q[5:0];
  assign bus.a_we        = 1'b0;
  assign bus.c_we        = c_we_q;
  assign bus.c_addr      = c_addr_q;
  assign bus.c_data      = c_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_matmul_dot_engine.sv
// Bench for matmul_dot_engine: table of matrix patterns plus reset/restart sequences.
module tb_matmul_dot_engine;

  logic clk;
  logic reset;

  matmul_dot_if #(.DATA_W(8), .ACC_W(19)) bus ();

  matmul_dot_engine #(.DATA_W(8), .DIM(8), .ACC_W(19)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [7:0] a_mem [64];
  logic signed [7:0] b_mem [64];
  longint            exp_c [64];

  // Registered-read dual-port operand RAMs
  always @(posedge clk) begin
    bus.a_data1 <= a_mem[bus.a_addr1];
    bus.a_data2 <= a_mem[bus.a_addr2];
    bus.b_data1 <= b_mem[bus.b_addr1];
    bus.b_data2 <= b_mem[bus.b_addr2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint relu(input longint v);
`ifdef MATMUL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Monitor: RUN-relative cycle, address pattern, and C write stream
  int rc = 0;
  int wr_cnt = 0;
  int addr_bad = 0;
  int stray = 0;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    int ea1, ea2, eb1, eb2;
    if (bus.busy) begin
      if (!prev_busy) begin
        rc = 0;
        wr_cnt = 0;
      end else begin
        rc++;
      end
    end
    prev_busy = bus.busy;
    ea1 = 0; ea2 = 0; eb1 = 0; eb2 = 0;
    if (bus.busy && rc < 256) begin
      ea1 = (rc / 32) * 8 + 2 * (rc % 4);
      ea2 = ea1 + 1;
      eb1 = (2 * (rc % 4)) * 8 + (rc / 4) % 8;
      eb2 = eb1 + 8;
    end
    if (int'(bus.a_addr1) != ea1 || int'(bus.a_addr2) != ea2 ||
        int'(bus.b_addr1) != eb1 || int'(bus.b_addr2) != eb2 || bus.a_we !== 1'b0)
      addr_bad++;
    if (bus.c_we) begin
      if (!bus.busy || wr_cnt >= 64) begin
        stray++;
      end else begin
        chk("c_addr", longint'(bus.c_addr), longint'(wr_cnt));
        chk("c_cycle", longint'(rc), longint'(4 * wr_cnt + 5));
        chk("c_data", longint'(bus.c_data), exp_c[wr_cnt]);
        wr_cnt++;
      end
    end
  end

  typedef struct {
    string  name;
    int     ka;
    int     kb;
    int     exp_kind;   // 0 model, 1 constant, 2 equals B
    longint cval;
  } tv_t;

  function automatic logic signed [7:0] gen(input int kind, input int r, input int c);
    case (kind)
      0: return (r == c) ? 8'sd1 : 8'sd0;
      1: return 8'(r * 8 + c);
      2: return -8'sd128;
      3: return 8'sd127;
      4: return 8'(c - 4);
      5: return 8'(r - 4);
      6: return 8'($urandom_range(0, 255));
      default: return ($urandom_range(0, 1) != 0) ? 8'sd127 : -8'sd128;
    endcase
  endfunction

  task automatic setup(input tv_t t);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a_mem[r*8+c] = gen(t.ka, r, c);
        b_mem[r*8+c] = gen(t.kb, r, c);
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        longint s;
        s = 0;
        for (int k = 0; k < 8; k++) s += longint'(a_mem[i*8+k]) * longint'(b_mem[k*8+j]);
        case (t.exp_kind)
          1:       exp_c[i*8+j] = relu(t.cval);
          2:       exp_c[i*8+j] = relu(longint'(b_mem[i*8+j]));
          default: exp_c[i*8+j] = relu(s);
        endcase
      end
  endtask

  task automatic launch();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  // Called at the negedge of RUN cycle 0; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input bit poke50);
    int dc;
    dc = -1;
    for (int c = 1; c < 600; c++) begin
      @(negedge clk);
      if (poke50 && c == 50) bus.start = 1'b1;
      if (poke50 && c == 51) bus.start = 1'b0;
      if (bus.done) begin
        dc = c;
        break;
      end
    end
    chk({tag, "_done_cycle"}, longint'(dc), 258);
  endtask

  task automatic post_checks(input string tag);
    chk({tag, "_cycle_count"}, longint'(bus.cycle_count), 259);
    chk({tag, "_busy_after"}, longint'(bus.busy), 0);
    chk({tag, "_writes"}, longint'(wr_cnt), 64);
    chk({tag, "_addr_bad"}, longint'(addr_bad), 0);
  endtask

  tv_t tv [7];

  initial begin
    tv[0] = '{"ident_ramp", 0, 1, 2, 0};
    tv[1] = '{"neg_neg",    2, 2, 1, 131072};
    tv[2] = '{"neg_pos",    2, 3, 1, -130048};
    tv[3] = '{"signed_mix", 4, 5, 1, 44};
    tv[4] = '{"random_a",   6, 6, 0, 0};
    tv[5] = '{"random_b",   6, 6, 0, 0};
    tv[6] = '{"extremes",   7, 7, 0, 0};

    bus.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_c_we", longint'(bus.c_we), 0);
    chk("rst_c_addr", longint'(bus.c_addr), 0);
    chk("rst_c_data", longint'(bus.c_data), 0);
    chk("rst_cycle_count", longint'(bus.cycle_count), 0);
    chk("rst_addrs", longint'({bus.a_addr1, bus.a_addr2, bus.b_addr1, bus.b_addr2}), 0);
    reset = 1'b0;

    // start coinciding with reset is swallowed
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", longint'(bus.busy), 0);
    @(negedge clk);
    chk("rst_start_busy2", longint'(bus.busy), 0);

    for (int t = 0; t < 7; t++) begin
      setup(tv[t]);
      launch();
      chk({tv[t].name, "_busy0"}, longint'(bus.busy), 1);
      wait_done(tv[t].name, 1'b0);
      @(negedge clk);
      post_checks(tv[t].name);
    end

    // Reset in the middle of a run
    setup(tv[4]);
    launch();
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", longint'(bus.busy), 0);
    chk("midrst_c_we", longint'(bus.c_we), 0);
    chk("midrst_done", longint'(bus.done), 0);
    chk("midrst_cycle_count", longint'(bus.cycle_count), 0);
    chk("midrst_c_data", longint'(bus.c_data), 0);
    chk("midrst_addrs", longint'({bus.a_addr1, bus.a_addr2, bus.b_addr1, bus.b_addr2}), 0);
    repeat (20) @(negedge clk);
    chk("midrst_stray_we", longint'(stray), 0);
    chk("midrst_idle", longint'(bus.busy), 0);
    launch();
    wait_done("after_rst", 1'b0);
    @(negedge clk);
    post_checks("after_rst");

    // Extra starts in RUN and DONE are ignored; start right after DONE relaunches
    setup(tv[5]);
    launch();
    wait_done("poke", 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    post_checks("poke");
    @(negedge clk);
    bus.start = 1'b0;
    chk("relaunch_busy", longint'(bus.busy), 1);
    wait_done("relaunch", 1'b0);
    @(negedge clk);
    post_checks("relaunch");

    repeat (5) @(negedge clk);
    chk("final_stray_we", longint'(stray), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
